// File: rtl/rns_modmult_pkg.sv
// rns_modmult_pkg: shared types and elaboration-time helpers for the RNS modular pipeline.
//   op_e          : operation encoding carried alongside each beat
//   barrett_mu()  : floor(2^(2w) / m), the per-channel Barrett constant
//   chan_modulus(): extracts the channel-k modulus from a packed modulus vector
package rns_modmult_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  function automatic logic [63:0] barrett_mu(input logic [63:0] m, input int unsigned w);
    return 64'((128'(1) << (2 * w)) / 128'(m));
  endfunction

  // Callers zero-extend their packed vector to 1024 bits so one signature serves any NCH*W.
  function automatic logic [63:0] chan_modulus(input logic [1023:0] moduli,
                                               input int unsigned w,
                                               input int unsigned k);
    return 64'((moduli >> (k * w)) & ((1024'(1) << w) - 1024'(1)));
  endfunction

endpackage

// File: rtl/rns_modmult_pipe_if.sv
// rns_modmult_pipe_if: operand/result stream bundle for rns_modmult_pipe.
//   in_*  : operand beat (valid/ready, op, packed A/B residues, tag)
//   out_* : result beat (valid/ready, packed results, tag, range error)
//   master: producer of operands / consumer of results; slave: the pipeline.
interface rns_modmult_pipe_if #(
  parameter int unsigned W     = 18,
  parameter int unsigned NCH   = 2,
  parameter int unsigned TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_op;
  logic [NCH*W-1:0]   in_a;
  logic [NCH*W-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [NCH*W-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/rns_modmult_lane.sv
// rns_modmult_lane: one residue channel, stages S2..S4 of the modular pipeline.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : shared pipeline advance; all stage registers hold when low
//   op_i     : operation of the beat sitting in S1
//   a_i, b_i : S1 residues for this channel
//   res_o    : S4 result, (a op b) mod M
// S2 forms the raw value, S3 takes a Barrett estimate, S4 does two conditional subtracts.
// The estimate is within 2 of the true quotient when 2^(W-1) <= M < 2^W.
module rns_modmult_lane
  import rns_modmult_pkg::*;
#(
  parameter int unsigned  W = 18,
  parameter logic [W-1:0] M = 18'd262139
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o
);

  localparam int unsigned  PW = 3 * W + 2;
  localparam logic [2*W:0] Mu = (2*W+1)'(barrett_mu(64'(M), W));

  logic [2*W-1:0] x_new, x_d, x_q;
  logic [2*W-1:0] q;
  logic [W+1:0]   r_d, r_q, r1;
  logic [W-1:0]   res_d, res_q;

  // S2: raw value; SUB folds in +M when a < b so the value stays non-negative.
  always_comb begin
    x_new = '0;
    unique case (op_i)
      OP_MUL:  x_new = (2*W)'(a_i) * (2*W)'(b_i);
      OP_ADD:  x_new = (2*W)'(a_i) + (2*W)'(b_i);
      OP_SUB:  x_new = (a_i < b_i) ? (2*W)'(a_i) + (2*W)'(M) - (2*W)'(b_i)
                                   : (2*W)'(a_i) - (2*W)'(b_i);
      OP_PASS: x_new = (2*W)'(a_i);
      default: x_new = '0;
    endcase
    x_d = en_i ? x_new : x_q;
  end

  // S3: q never exceeds floor(x/M), so x - q*M cannot underflow and stays below 3M.
  assign q   = (2*W)'((PW'(x_q >> (W - 1)) * PW'(Mu)) >> (W + 1));
  assign r_d = en_i ? (W+2)'(x_q - q * (2*W)'(M)) : r_q;

  // S4
  always_comb begin
    r1    = (r_q >= (W+2)'(M)) ? r_q - (W+2)'(M) : r_q;
    res_d = res_q;
    if (en_i) res_d = W'((r1 >= (W+2)'(M)) ? r1 - (W+2)'(M) : r1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      r_q   <= '0;
      res_q <= '0;
    end else begin
      x_q   <= x_d;
      r_q   <= r_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/rns_modmult_pipe.sv
// rns_modmult_pipe: NCH-channel RNS modular MUL/ADD/SUB/PASS pipeline, 4-cycle latency.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rns_modmult_pipe_if.slave (operand stream in, result stream out)
// S1 lives here (operands, op, tag, range flag); lanes hold S2..S4 datapath per channel.
// The whole pipe advances together when the output slot is empty or being taken.
// Build option: define RNS_MODMULT_RANGE_CHK_EN to flag beats with a or b >= modulus on
// out_err; otherwise out_err is constant 0.
module rns_modmult_pipe
  import rns_modmult_pkg::*;
#(
  parameter int unsigned      W      = 18,
  parameter int unsigned      NCH    = 2,
  parameter logic [NCH*W-1:0] MODULI = {18'd177147, 18'd262139},
  parameter int unsigned      TAG_W  = 4
) (
  input logic               clk,
  input logic               rst,
  rns_modmult_pipe_if.slave bus
);

  localparam int unsigned NSTG = 4;

  logic                        adv;
  logic [NSTG-1:0]             vld_d, vld_q;
  logic [NSTG-1:0]             err_d, err_q;
  logic [NSTG-1:0][TAG_W-1:0]  tag_d, tag_q;
  op_e                         op_d, op_q;
  logic [NCH*W-1:0]            a_d, a_q, b_d, b_q;
  logic [NCH-1:0]              ch_err;
  logic                        range_err;
  logic [NCH*W-1:0]            res;

  // Combinational from out_ready so a stall stops intake in the same cycle.
  assign adv          = !vld_q[NSTG-1] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    tag_d = tag_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    if (adv) begin
      vld_d = {vld_q[NSTG-2:0], bus.in_valid};
      err_d = {err_q[NSTG-2:0], range_err};
      tag_d = {tag_q[NSTG-2:0], bus.in_tag};
      op_d  = op_e'(bus.in_op);
      a_d   = bus.in_a;
      b_d   = bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      tag_q <= '0;
      op_q  <= OP_MUL;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      tag_q <= tag_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [W-1:0] Mk = W'(chan_modulus(1024'(MODULI), W, k));

`ifdef RNS_MODMULT_RANGE_CHK_EN
    assign ch_err[k] = (bus.in_a[k*W +: W] >= Mk) || (bus.in_b[k*W +: W] >= Mk);
`else
    assign ch_err[k] = 1'b0;
`endif

    rns_modmult_lane #(
      .W (W),
      .M (Mk)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (adv),
      .op_i  (op_q),
      .a_i   (a_q[k*W +: W]),
      .b_i   (b_q[k*W +: W]),
      .res_o (res[k*W +: W])
    );
  end

  assign range_err     = |ch_err;
  assign bus.out_valid = vld_q[NSTG-1];
  assign bus.out_data  = res;
  assign bus.out_tag   = tag_q[NSTG-1];
  assign bus.out_err   = err_q[NSTG-1];

endmodule

// File: tb/tb_rns_modmult_pipe.sv
// tb_rns_modmult_pipe: directed + randomized checks of rns_modmult_pipe against a plain
// arithmetic model (mod operator on 64-bit integers).
module tb_rns_modmult_pipe;

  localparam int unsigned      W      = 18;
  localparam int unsigned      NCH    = 2;
  localparam int unsigned      TAG_W  = 4;
  localparam logic [NCH*W-1:0] MODULI = {18'd177147, 18'd262139};
  localparam longint unsigned  M0     = 262139;
  localparam longint unsigned  M1     = 177147;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rns_modmult_pipe_if #(.W(W), .NCH(NCH), .TAG_W(TAG_W)) bus ();

  rns_modmult_pipe #(
    .W      (W),
    .NCH    (NCH),
    .MODULI (MODULI),
    .TAG_W  (TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned ref_res(input int op, input longint unsigned a,
                                              input longint unsigned b,
                                              input longint unsigned m);
    case (op)
      0:       return (a * b) % m;
      1:       return (a + b) % m;
      2:       return (a + m - b) % m;
      default: return a;
    endcase
  endfunction

  function automatic logic [35:0] ref_pack(input int op, input longint unsigned a0,
                                           input longint unsigned b0,
                                           input longint unsigned a1,
                                           input longint unsigned b1);
    return {18'(ref_res(op, a1, b1, M1)), 18'(ref_res(op, a0, b0, M0))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input longint unsigned a0, input longint unsigned b0,
                       input longint unsigned a1, input longint unsigned b1,
                       input logic [3:0] tag);
    bus.in_op  = 2'(op);
    bus.in_a   = {18'(a1), 18'(a0)};
    bus.in_b   = {18'(b1), 18'(b0)};
    bus.in_tag = tag;
  endtask

  // One beat into an empty pipe; checks latency, data, tag and error flag.
  task automatic run_one(input string name, input int op,
                         input longint unsigned a0, input longint unsigned b0,
                         input longint unsigned a1, input longint unsigned b1,
                         input logic [3:0] tag, input bit chk_data, input bit exp_err);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(op, a0, b0, a1, b1, tag);
    #1;
    check({name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check({name, ".early"}, 64'(bus.out_valid), 64'd0);
    step();
    check({name, ".valid"}, 64'(bus.out_valid), 64'd1);
    if (chk_data) check({name, ".data"}, 64'(bus.out_data), 64'(ref_pack(op, a0, b0, a1, b1)));
    check({name, ".tag"}, 64'(bus.out_tag), 64'(tag));
    check({name, ".err"}, 64'(bus.out_err), 64'(exp_err));
    step();
  endtask

  logic [35:0]       exp_data_q[$];
  logic [3:0]        exp_tag_q[$];
  int                sent, rcvd;
  bit                hold;
  logic [35:0]       hold_data;
  logic [3:0]        hold_tag;
  int                c_op;
  longint unsigned   c_a0, c_b0, c_a1, c_b1;
  bit                range_on;

  initial begin
`ifdef RNS_MODMULT_RANGE_CHK_EN
    range_on = 1'b1;
`else
    range_on = 1'b0;
`endif
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 4'h0);
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst.valid", 64'(bus.out_valid), 64'd0);
    check("rst.data", 64'(bus.out_data), 64'd0);
    check("rst.tag", 64'(bus.out_tag), 64'd0);
    check("rst.err", 64'(bus.out_err), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);

    // Directed boundary and example beats.
    run_one("mul_1e5", 0, 100000, 100000, 100000, 100000, 4'h1, 1'b1, 1'b0);
    check("mul_1e5.ch1", 64'(bus.out_data[35:18]), 64'd51850);
    run_one("mul_max", 0, M0 - 1, M0 - 1, M1 - 1, M1 - 1, 4'h2, 1'b1, 1'b0);
    run_one("add_max", 1, M0 - 1, M0 - 1, M1 - 1, M1 - 1, 4'h3, 1'b1, 1'b0);
    run_one("sub_max", 2, M0 - 1, M0 - 1, M1 - 1, M1 - 1, 4'h4, 1'b1, 1'b0);
    run_one("sub_neg", 2, 5, 7, 5, 7, 4'h5, 1'b1, 1'b0);
    run_one("pass", 3, 1234, $urandom_range(32'(M0 - 1)), 1234, $urandom_range(32'(M1 - 1)),
            4'h6, 1'b1, 1'b0);
    run_one("add_a0", 1, 0, $urandom_range(32'(M0 - 1)), 0, $urandom_range(32'(M1 - 1)),
            4'h7, 1'b1, 1'b0);
    run_one("mul_b0", 0, $urandom_range(32'(M0 - 1)), 0, $urandom_range(32'(M1 - 1)), 0,
            4'h8, 1'b1, 1'b0);
    run_one("sub_b0", 2, $urandom_range(32'(M0 - 1)), 0, $urandom_range(32'(M1 - 1)), 0,
            4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_one("rand", int'($urandom_range(3)), $urandom_range(32'(M0 - 1)),
              $urandom_range(32'(M0 - 1)), $urandom_range(32'(M1 - 1)),
              $urandom_range(32'(M1 - 1)), 4'(i), 1'b1, 1'b0);
    end

    // Range flag: only the out-of-range beat may carry it.
    run_one("range_bad", 0, 5, 5, M1, 3, 4'hB, 1'b0, range_on);
    run_one("range_ok", 0, 5, 5, M1 - 1, 3, 4'hC, 1'b1, 1'b0);

    // Streaming with random backpressure and input gaps.
    sent = 0;
    rcvd = 0;
    hold = 1'b0;
    c_op = int'($urandom_range(3));
    c_a0 = $urandom_range(32'(M0 - 1));
    c_b0 = $urandom_range(32'(M0 - 1));
    c_a1 = $urandom_range(32'(M1 - 1));
    c_b1 = $urandom_range(32'(M1 - 1));
    for (int cyc = 0; cyc < 400 && rcvd < 16; cyc++) begin
      bus.out_ready = ($urandom_range(99) < 55);
      bus.in_valid  = (sent < 16) && ($urandom_range(3) != 0);
      drive(c_op, c_a0, c_b0, c_a1, c_b1, 4'(sent));
      #1;
      check("stream.in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (hold) begin
        check("stream.stable", 64'({bus.out_valid, bus.out_data, bus.out_tag}),
              64'({1'b1, hold_data, hold_tag}));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("stream.nonempty", 64'(exp_tag_q.size() > 0), 64'd1);
        if (exp_tag_q.size() > 0) begin
          check("stream.tag", 64'(bus.out_tag), 64'(exp_tag_q.pop_front()));
          check("stream.data", 64'(bus.out_data), 64'(exp_data_q.pop_front()));
        end
        rcvd++;
      end
      hold      = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_tag  = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        exp_data_q.push_back(ref_pack(c_op, c_a0, c_b0, c_a1, c_b1));
        exp_tag_q.push_back(4'(sent));
        sent++;
        c_op = int'($urandom_range(3));
        c_a0 = $urandom_range(32'(M0 - 1));
        c_b0 = $urandom_range(32'(M0 - 1));
        c_a1 = $urandom_range(32'(M1 - 1));
        c_b1 = $urandom_range(32'(M1 - 1));
      end
      step();
    end
    check("stream.count", 64'(rcvd), 64'd16);
    check("stream.leftover", 64'(exp_tag_q.size()), 64'd0);

    // Reset with three beats in flight, plus an input offered during reset.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      drive(0, 100 + i, 200, 300 + i, 400, 4'(i + 1));
      step();
    end
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 4'hA);
    step();
    check("mid_rst.valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst.data", 64'(bus.out_data), 64'd0);
    check("mid_rst.tag", 64'(bus.out_tag), 64'd0);
    check("mid_rst.in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mid_rst.no_stale", 64'(bus.out_valid), 64'd0);
    end
    run_one("post_rst", 0, 100000, 100000, 100000, 100000, 4'hE, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
